// File: rtl/wb_spi_slave.sv
// wb_spi_slave: SPI mode-0 target (8-bit, MSB first) with a Wishbone
// register window (RXDATA/TXDATA/STATUS/CTRL) for the LM32 conbus.
// Optional macro: SPI_SLAVE_IRQ_EN enables the CTRL register and intr.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   wb_*             Wishbone slave (adr[3:2] decoded, sel ignored)
//   spi_sck/mosi/cs_n  external master inputs (synchronised here)
//   spi_miso/_oe     target data out and its tri-state enable
//   intr             interrupt request (tied 0 without the macro)
module wb_spi_slave #(
    parameter logic [7:0]  idle_byte   = 8'h00,
    parameter int unsigned sync_stages = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        intr
);

    logic [sync_stages-1:0] sck_sync_q, sck_sync_d;
    logic [sync_stages-1:0] mosi_sync_q, mosi_sync_d;
    logic [sync_stages-1:0] cs_sync_q, cs_sync_d;
    logic       sck_prev_q, sck_prev_d;
    logic       cs_prev_q, cs_prev_d;
    logic       active_q, active_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       rx_full_q, rx_full_d;
    logic       tx_full_q, tx_full_d;
    logic       overrun_q, overrun_d;
    logic       miso_q, miso_d;
    logic       ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
`ifdef SPI_SLAVE_IRQ_EN
    logic       ien_q, ien_d;
    logic       intr_q, intr_d;
`endif

    logic       sck_s, mosi_s, cs_s;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;
    logic       hit, rd_rx, wr_tx, wr_st, wr_ctrl;
    logic       tx_load, frame_done;
    logic [7:0] load_val, rx_byte;
    logic [31:0] rdata;
    logic       unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0],
                         wb_dat_i[31:8], wr_ctrl};

    assign sck_s  = sck_sync_q[sync_stages-1];
    assign mosi_s = mosi_sync_q[sync_stages-1];
    assign cs_s   = cs_sync_q[sync_stages-1];

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    assign hit     = wb_stb_i & wb_cyc_i & ~ack_q;
    assign rd_rx   = hit & ~wb_we_i & (wb_adr_i[3:2] == 2'd0);
    assign wr_tx   = hit & wb_we_i & (wb_adr_i[3:2] == 2'd1);
    assign wr_st   = hit & wb_we_i & (wb_adr_i[3:2] == 2'd2);
    assign wr_ctrl = hit & wb_we_i & (wb_adr_i[3:2] == 2'd3);

    assign load_val = tx_full_q ? tx_hold_q : idle_byte;
    assign rx_byte  = {rx_sr_q[6:0], mosi_s};

    always_comb begin
        rdata = 32'h0;
        unique case (wb_adr_i[3:2])
            2'd0: rdata = {24'h0, rx_data_q};
            2'd1: rdata = 32'h0;
            2'd2: rdata = {28'h0, active_q, overrun_q, ~tx_full_q, rx_full_q};
`ifdef SPI_SLAVE_IRQ_EN
            2'd3: rdata = {31'h0, ien_q};
`else
            2'd3: rdata = 32'h0;
`endif
        endcase
    end

    always_comb begin
        sck_sync_d  = {sck_sync_q[sync_stages-2:0], spi_sck};
        mosi_sync_d = {mosi_sync_q[sync_stages-2:0], spi_mosi};
        cs_sync_d   = {cs_sync_q[sync_stages-2:0], spi_cs_n};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
        active_d    = active_q;
        cnt_d       = cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        rx_data_d   = rx_data_q;
        tx_hold_d   = tx_hold_q;
        rx_full_d   = rx_full_q;
        tx_full_d   = tx_full_q;
        overrun_d   = overrun_q;
        miso_d      = miso_q;
        ack_d       = hit;
        dat_d       = hit ? rdata : 32'h0;
        tx_load     = 1'b0;
        frame_done  = 1'b0;

        if (cs_rise) begin
            active_d = 1'b0;
            cnt_d    = 3'd0;
            miso_d   = 1'b0;
            rx_sr_d  = 8'h00;
        end else if (cs_fall) begin
            active_d = 1'b1;
            cnt_d    = 3'd0;
            rx_sr_d  = 8'h00;
            tx_sr_d  = load_val;
            miso_d   = load_val[7];
            tx_load  = 1'b1;
        end else if (active_q) begin
            if (sck_rise) begin
                rx_sr_d    = rx_byte;
                cnt_d      = cnt_q + 3'd1;
                frame_done = (cnt_q == 3'd7);
            end else if (sck_fall) begin
                if (cnt_q != 3'd0) begin
                    tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    miso_d  = tx_sr_q[6];
                end else begin
                    tx_sr_d = load_val;
                    miso_d  = load_val[7];
                    tx_load = 1'b1;
                end
            end
        end

        // A read acked with completion frees the slot for the new byte.
        if (rd_rx) rx_full_d = 1'b0;
        if (wr_st && wb_dat_i[2]) overrun_d = 1'b0;
        if (frame_done) begin
            if (!rx_full_q || rd_rx) begin
                rx_data_d = rx_byte;
                rx_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        // Load sees the pre-write holding state; the write lands after.
        if (tx_load) tx_full_d = 1'b0;
        if (wr_tx) begin
            tx_hold_d = wb_dat_i[7:0];
            tx_full_d = 1'b1;
        end

`ifdef SPI_SLAVE_IRQ_EN
        ien_d  = wr_ctrl ? wb_dat_i[0] : ien_q;
        intr_d = ien_q & (rx_full_q | overrun_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // cs sync resets "low" so a frame already in progress
            // produces no falling edge and stays ignored.
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
            active_q    <= 1'b0;
            cnt_q       <= 3'd0;
            rx_sr_q     <= 8'h00;
            tx_sr_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            tx_hold_q   <= 8'h00;
            rx_full_q   <= 1'b0;
            tx_full_q   <= 1'b0;
            overrun_q   <= 1'b0;
            miso_q      <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= 32'h0;
`ifdef SPI_SLAVE_IRQ_EN
            ien_q       <= 1'b0;
            intr_q      <= 1'b0;
`endif
        end else begin
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rx_data_q   <= rx_data_d;
            tx_hold_q   <= tx_hold_d;
            rx_full_q   <= rx_full_d;
            tx_full_q   <= tx_full_d;
            overrun_q   <= overrun_d;
            miso_q      <= miso_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
`ifdef SPI_SLAVE_IRQ_EN
            ien_q       <= ien_d;
            intr_q      <= intr_d;
`endif
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign spi_miso    = miso_q;
    assign spi_miso_oe = active_q;
`ifdef SPI_SLAVE_IRQ_EN
    assign intr = intr_q;
`else
    assign intr = 1'b0;
`endif

endmodule

// File: tb/tb_wb_spi_slave.sv
// tb_wb_spi_slave: self-checking bench for wb_spi_slave.
// Frame table with scoreboard plus hand-written corner sequences.
module tb_wb_spi_slave;

    localparam int HALF = 8;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
    logic [3:0]  wb_sel_i;
    logic        spi_sck, spi_mosi, spi_cs_n, spi_miso, spi_miso_oe;
    logic        intr;

    always #5 clk = ~clk;

    wb_spi_slave #(.idle_byte(8'h00), .sync_stages(SYNC)) dut (
        .clk(clk), .reset(reset),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .intr(intr)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         wr_tx;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t        vecs[4];
    logic [15:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_cycle(input logic we, input logic [3:0] adr,
                            input logic [31:0] wd, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd = 32'hx;
        wb_adr_i = {28'h0, adr};
        wb_dat_i = wd;
        wb_we_i  = we;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            wait_clk(1);
            if (wb_ack_o) begin
                got = 1'b1;
                rd = wb_dat_o;
            end
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        chk("wb_ack_seen", {31'h0, got}, 32'h1);
        wait_clk(1);
        chk("wb_single_ack", {31'h0, wb_ack_o}, 32'h0);
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] rd);
        wb_cycle(1'b0, adr, 32'h0, rd);
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_cycle(1'b1, adr, wd, dummy);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int n,
                            output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = mo[7-i];
            wait_clk(HALF);
            mi = {mi[6:0], spi_miso};
            spi_sck = 1'b1;
            wait_clk(HALF);
            spi_sck = 1'b0;
        end
        wait_clk(HALF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  mi, mi2;
        logic [15:0] exp;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b0, 8'h00, 8'hE7, 8'h00, 8'hE7};
        vecs[2] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[3] = '{1'b1, 8'h01, 8'h80, 8'h01, 8'h80};

        reset = 1'b1;
        wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(1);
        chk("rst_ack", {31'h0, wb_ack_o}, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_miso", {31'h0, spi_miso}, 32'h0);
        chk("rst_oe", {31'h0, spi_miso_oe}, 32'h0);
        chk("rst_intr", {31'h0, intr}, 32'h0);
        wait_clk(4);
        wb_read(4'h8, rd);
        chk("rst_status", rd, 32'h2);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].wr_tx) wb_write(4'h4, {24'h0, vecs[i].tx});
            sb_q.push_back({vecs[i].exp_miso, vecs[i].exp_rx});
            cs_low();
            chk("sel_oe", {31'h0, spi_miso_oe}, 32'h1);
            wb_read(4'h8, rd);
            chk("sel_status", rd, 32'hA);
            spi_bits(vecs[i].mosi, 8, mi);
            cs_high();
            chk("desel_oe", {31'h0, spi_miso_oe}, 32'h0);
            chk("desel_miso", {31'h0, spi_miso}, 32'h0);
            exp = sb_q.pop_front();
            chk("miso_byte", {24'h0, mi}, {24'h0, exp[15:8]});
            wb_read(4'h8, rd);
            chk("frame_status", rd, 32'h3);
            wb_read(4'h0, rd);
            chk("rxdata", rd, {24'h0, exp[7:0]});
            wb_read(4'h8, rd);
            chk("status_after_rd", rd, 32'h2);
        end

        // Two frames, no TX write: idle bytes, second frame overruns.
        cs_low();
        spi_bits(8'h12, 8, mi);
        spi_bits(8'h34, 8, mi2);
        cs_high();
        chk("idle_miso0", {24'h0, mi}, 32'h0);
        chk("idle_miso1", {24'h0, mi2}, 32'h0);
        wb_read(4'h8, rd);
        chk("ovr_status", rd, 32'h7);
        wb_read(4'h0, rd);
        chk("ovr_rxdata", rd, 32'h12);
        wb_write(4'h8, 32'h4);
        wb_read(4'h8, rd);
        chk("ovr_cleared", rd, 32'h2);

        // Partial frame then deselect.
        cs_low();
        spi_bits(8'hFF, 5, mi);
        cs_high();
        wb_read(4'h8, rd);
        chk("partial_status", rd, 32'h2);
        cs_low();
        spi_bits(8'h81, 8, mi);
        cs_high();
        wb_read(4'h0, rd);
        chk("after_partial_rx", rd, 32'h81);

        // RXDATA read acked on the clk the next frame completes.
        cs_low();
        spi_bits(8'h11, 8, mi);
        spi_bits(8'h55, 7, mi);
        spi_mosi = 1'b1;
        wait_clk(HALF);
        spi_sck = 1'b1;
        wait_clk(SYNC);
        wb_adr_i = 32'h0; wb_we_i = 1'b0;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        wait_clk(1);
        chk("coinc_ack", {31'h0, wb_ack_o}, 32'h1);
        chk("coinc_old", wb_dat_o, 32'h11);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        wait_clk(HALF);
        spi_sck = 1'b0;
        wait_clk(HALF);
        cs_high();
        wb_read(4'h8, rd);
        chk("coinc_status", rd, 32'h3);
        wb_read(4'h0, rd);
        chk("coinc_new", rd, 32'h55);

        // Reset during bit 4 of a frame.
        wb_write(4'h4, 32'hFF);
        cs_low();
        spi_bits(8'hF0, 4, mi);
        chk("pre_rst_miso", {31'h0, spi_miso}, 32'h1);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        chk("mid_rst_miso", {31'h0, spi_miso}, 32'h0);
        chk("mid_rst_oe", {31'h0, spi_miso_oe}, 32'h0);
        chk("mid_rst_ack", {31'h0, wb_ack_o}, 32'h0);
        chk("mid_rst_dat", wb_dat_o, 32'h0);
        wb_read(4'h8, rd);
        chk("mid_rst_status", rd, 32'h2);
        spi_bits(8'hF0, 4, mi);
        cs_high();
        wb_read(4'h8, rd);
        chk("ignored_frame", rd, 32'h2);
        cs_low();
        spi_bits(8'hC3, 8, mi);
        cs_high();
        wb_read(4'h0, rd);
        chk("post_rst_rx", rd, 32'hC3);

`ifdef SPI_SLAVE_IRQ_EN
        wb_write(4'hC, 32'h1);
        wb_read(4'hC, rd);
        chk("ctrl_rd", rd, 32'h1);
        chk("irq_idle", {31'h0, intr}, 32'h0);
        cs_low();
        spi_bits(8'h5A, 8, mi);
        chk("irq_set", {31'h0, intr}, 32'h1);
        wb_read(4'h0, rd);
        chk("irq_rx", rd, 32'h5A);
        chk("irq_clr", {31'h0, intr}, 32'h0);
        cs_high();
`else
        wb_write(4'hC, 32'h1);
        wb_read(4'hC, rd);
        chk("ctrl_absent", rd, 32'h0);
        cs_low();
        spi_bits(8'h5A, 8, mi);
        cs_high();
        chk("intr_tied", {31'h0, intr}, 32'h0);
        wb_read(4'h0, rd);
        chk("noirq_rx", rd, 32'h5A);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
